// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state encodings for the bit-serial adder
package serial_adder_pkg;

    // FSM states kept as plain 2-bit constants so the encoding is fixed and
    // visible in waveforms.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// rtl/serial_adder_fa_cell.sv - combinational one-bit full adder cell
//
// Ports:
//   i_a, i_b  operand bits
//   i_ci      carry in
//   o_s       sum bit
//   o_co      carry out (majority of the three inputs)
module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one bit per clock, LSB first
//
// Parameters:
//   WIDTH     operand/sum width in bits (>= 2)
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     load a_in/b_in/cin and begin an add (accepted in IDLE or DONE only)
//   a_in      operand A
//   b_in      operand B
//   cin       carry in
//   busy      high while the add is running
//   done      one-cycle pulse when sum/cout are valid
//   sum       result, held from done until the next accepted start
//   ovf       two's-complement overflow (only when SERIAL_ADDER_OVF_EN is defined)
//   cout      carry out, held like sum
// Build option:
//   SERIAL_ADDER_OVF_EN  adds the ovf output and its register
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic w_s;
    logic w_co;
    logic w_accept;

    fa_cell u_fa (
        .i_a  (r_a_sr[0]),
        .i_b  (r_b_sr[0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    // A start arriving while running is dropped entirely.
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_a_sr  <= a_in;
            r_b_sr  <= b_in;
            r_carry <= cin;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_carry <= w_co;
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    // Sum bits enter at the MSB so after WIDTH shifts bit 0
                    // holds the first (LSB) result bit.
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_DONE;
                        r_cout  <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // On the last bit r_carry is the carry into the MSB.
                        r_ovf   <= r_carry ^ w_co;
`endif
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                ST_IDLE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=4)
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8;
    logic       ovf4;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a_in  (a8),
        .b_in  (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf8),
`endif
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a_in  (a4),
        .b_in  (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf4),
`endif
        .cout  (cout4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Signed overflow from operand/result signs: same-sign operands giving a
    // result of the other sign.
    function automatic logic ref_ovf(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    // Presents operands with start=1 right now (caller is away from the edge),
    // counts edges with the accept edge as edge 1, and checks the result.
    // inject_at > 0 pulses start with other operands during RUN.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input int inject_at, input string tag);
        int          n;
        logic [8:0]  full;
        full   = 9'(a) + 9'(b) + 9'(c);
        a8     = a;
        b8     = b;
        cin8   = c;
        start8 = 1'b1;
        n      = 0;
        while (n < 30) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
                start8 = 1'b0;
                check({tag, ".busy1"}, 32'(busy8), 32'd1);
            end
            if (inject_at > 0 && n == inject_at) begin
                a8 = ~a; b8 = a ^ 8'h3C; cin8 = ~c; start8 = 1'b1;
            end
            if (inject_at > 0 && n == inject_at + 1) start8 = 1'b0;
            if (done8) break;
        end
        check({tag, ".lat"}, 32'(n), 32'd9);
        check({tag, ".sum"}, 32'(sum8), 32'(full[7:0]));
        check({tag, ".cout"}, 32'(cout8), 32'(full[8]));
        check({tag, ".busy_done"}, 32'(busy8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, ".ovf"}, 32'(ovf8), 32'(ref_ovf(a[7], b[7], full[7])));
`endif
    endtask

    task automatic add4(input logic [3:0] a, input logic [3:0] b, input logic c);
        int         n;
        logic [4:0] full;
        full   = 5'(a) + 5'(b) + 5'(c);
        a4     = a;
        b4     = b;
        cin4   = c;
        start4 = 1'b1;
        n      = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) start4 = 1'b0;
            if (done4) break;
        end
        check("w4.lat", 32'(n), 32'd5);
        check("w4.res", 32'({cout4, sum4}), 32'(full));
`ifdef SERIAL_ADDER_OVF_EN
        check("w4.ovf", 32'(ovf4), 32'(ref_ovf(a[3], b[3], full[3])));
`endif
    endtask

    initial begin
        logic [7:0] held;

        // Reset state
        #1;
        check("rst.busy", 32'(busy8), 32'd0);
        check("rst.done", 32'(done8), 32'd0);
        check("rst.sum", 32'(sum8), 32'h00);
        check("rst.cout", 32'(cout8), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases
        add8(8'h00, 8'h00, 1'b0, 0, "zero");
        @(posedge clk); #1;
        check("zero.done_drop", 32'(done8), 32'd0);
        check("zero.hold", 32'(sum8), 32'h00);
        @(negedge clk);
        add8(8'hFF, 8'h01, 1'b0, 0, "ff01");
        @(negedge clk);
        add8(8'h7F, 8'h01, 1'b0, 0, "7f01");
        @(negedge clk);
        add8(8'hA5, 8'h5A, 1'b1, 0, "a55a");

        // Hold after done until next start
        held = sum8;
        repeat (3) @(posedge clk);
        #1;
        check("hold.sum", 32'(sum8), 32'(held));
        check("hold.cout", 32'(cout8), 32'd1);

        // start during RUN is ignored
        @(negedge clk);
        add8(8'h12, 8'h34, 1'b0, 3, "ignore");

        // Back-to-back: restart while done is high
        @(negedge clk);
        add8(8'h80, 8'h80, 1'b0, 0, "b2b1");
        add8(8'h3C, 8'h44, 1'b1, 0, "b2b2");

        // Reset mid-RUN aborts with no done
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(busy8), 32'd0);
        check("abort.done", 32'(done8), 32'd0);
        check("abort.sum", 32'(sum8), 32'h00);
        check("abort.cout", 32'(cout8), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("abort.nodone", 32'(done8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        add8(8'h55, 8'hAB, 1'b0, 0, "after_abort");

        // Randomized adds
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            add8(8'($urandom), 8'($urandom), 1'($urandom), 0, "rand");
        end

        // Exhaustive WIDTH=4 sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    add4(4'(a), 4'(b), 1'(c));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
